// File: rtl/cla_nibble_subtractor_pkg.sv
// Shared definitions for the nibble-serial borrow-lookahead subtractor.
package cla_nibble_subtractor_pkg;

  // Width of one lookahead slice; the datapath walks the operands in steps of this size.
  localparam int unsigned NIBBLE_W = 4;

  // Controller states: waiting for operands, stepping nibbles, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bla4_slice.sv
// Combinational 4-bit borrow-lookahead subtractor: d = a - b - bin, bout = borrow out of bit 3.
module bla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] w_g;   // bit generates a borrow on its own
  logic [3:0] w_p;   // bit passes an incoming borrow through
  logic [4:0] w_bc;  // borrow into each bit, w_bc[4] is the slice borrow-out

  assign w_g = ~a & b;
  assign w_p = ~(a ^ b);

  // Flattened lookahead: every borrow depends only on g/p and bin, not on the previous borrow.
  assign w_bc[0] = bin;
  assign w_bc[1] = w_g[0] | (w_p[0] & bin);
  assign w_bc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
  assign w_bc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bin);
  assign w_bc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

  assign d    = a ^ b ^ w_bc[3:0];
  assign bout = w_bc[4];

endmodule

// File: rtl/cla_nibble_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: one borrow-lookahead nibble per clock, LSB nibble first,
// with valid/ready handshakes on both the operand and the result side.
module cla_nibble_subtractor
  import cla_nibble_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             BorrowIN,
  output logic [WIDTH-1:0] DIFF,
  output logic             BorrowOUT,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int unsigned NIB_CNT = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB_CNT - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("cla_nibble_subtractor: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;  // running borrow between nibbles
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_done_valid;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_d_nib;
  logic                w_bout_nib;

  // Steer the current nibble of the captured operands into the single slice.
  always_comb begin
    w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
  end

  bla4_slice u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .bin  (r_borrow),
    .d    (w_d_nib),
    .bout (w_bout_nib)
  );

  // Controller and result registers; everything clears the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_borrow     <= 1'b0;
      r_diff       <= '0;
      r_bout       <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a      <= inp_a;
            r_b      <= inp_b;
            r_borrow <= BorrowIN;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_idx    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff[r_idx*NIBBLE_W +: NIBBLE_W] <= w_d_nib;
          r_borrow                           <= w_bout_nib;
          if (r_idx == IDX_LAST) begin
            r_bout       <= w_bout_nib;
            r_done_valid <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (done_ready) begin
            r_done_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ready only in IDLE, and forced low for as long as reset is held.
  always_comb begin
    start_ready = (r_state == IDLE) && !rst;
  end

  assign DIFF       = r_diff;
  assign BorrowOUT  = r_bout;
  assign done_valid = r_done_valid;

endmodule

// File: tb/tb_cla_nibble_subtractor.sv
// Self-checking bench for cla_nibble_subtractor (WIDTH=16): directed table, handshake and reset
// corner sequences, and random operands against an arithmetic reference.
module tb_cla_nibble_subtractor;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] inp_a;
  logic [WIDTH-1:0] inp_b;
  logic             BorrowIN;
  logic [WIDTH-1:0] DIFF;
  logic             BorrowOUT;
  logic             done_valid;
  logic             done_ready;

  int checks = 0;
  int errors = 0;

  cla_nibble_subtractor #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .inp_a       (inp_a),
    .inp_b       (inp_b),
    .BorrowIN    (BorrowIN),
    .DIFF        (DIFF),
    .BorrowOUT   (BorrowOUT),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 17-bit unsigned subtraction; bit 16 set means the result went negative.
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
    logic [16:0] t;
    t = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    return t;
  endfunction

  // Issue one operation from IDLE (called #1 after an edge). Returns the result seen when
  // done_valid first rises. Consumes it on the next edge if done_ready is high.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input bit scramble, input bit hold_valid,
                        output logic [15:0] d, output logic bo);
    int cyc;
    inp_a       = a;
    inp_b       = b;
    BorrowIN    = bin;
    start_valid = 1'b1;
    chk("start_ready_idle", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold_valid) start_valid = 1'b0;
    chk("cleared_on_accept", {15'd0, BorrowOUT, DIFF}, 32'd0);
    chk("start_ready_run", 32'(start_ready), 32'd0);
    cyc = 0;
    while (!done_valid && cyc < 40) begin
      if (scramble) begin
        inp_a    = 16'($urandom);
        inp_b    = 16'($urandom);
        BorrowIN = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd4);
    d  = DIFF;
    bo = BorrowOUT;
    if (done_ready) begin
      @(posedge clk); #1;
      chk("done_cleared", 32'(done_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] d;
    logic        bo;
    logic [16:0] exp;

    vecs[0] = '{a: 16'h1234, b: 16'h0234, bin: 1'b0, diff: 16'h1000, bout: 1'b0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, bin: 1'b0, diff: 16'hFFFF, bout: 1'b1};
    vecs[2] = '{a: 16'h8000, b: 16'h0000, bin: 1'b1, diff: 16'h7FFF, bout: 1'b0};
    vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, bin: 1'b1, diff: 16'hFFFF, bout: 1'b1};

    rst         = 1'b1;
    start_valid = 1'b0;
    inp_a       = '0;
    inp_b       = '0;
    BorrowIN    = 1'b0;
    done_ready  = 1'b1;

    #1;
    chk("reset_diff", 32'(DIFF), 32'd0);
    chk("reset_bout", 32'(BorrowOUT), 32'd0);
    chk("reset_done_valid", 32'(done_valid), 32'd0);
    chk("reset_start_ready", 32'(start_ready), 32'd0);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, 1'b0, d, bo);
      chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].diff));
      chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bout));
    end

    // Backpressure with start_valid held high the whole time
    done_ready = 1'b0;
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b1, d, bo);
    inp_a = 16'h0F00;
    inp_b = 16'h0001;
    chk("bp_diff", 32'(d), 32'h4B4B);
    chk("bp_bout", 32'(bo), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_done_valid_held", 32'(done_valid), 32'd1);
      chk("bp_diff_held", 32'(DIFF), 32'h4B4B);
      chk("bp_bout_held", 32'(BorrowOUT), 32'd0);
      chk("bp_start_ready_low", 32'(start_ready), 32'd0);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_done_valid", 32'(done_valid), 32'd0);
    run_op(16'h0F00, 16'h0001, 1'b0, 1'b0, 1'b0, d, bo);
    chk("bp_next_diff", 32'(d), 32'h0EFF);
    chk("bp_next_bout", 32'(bo), 32'd0);

    // Asynchronous reset two RUN cycles into an operation
    inp_a       = 16'h1234;
    inp_b       = 16'h0111;
    BorrowIN    = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_reset_partial", 32'(DIFF[7:0]), 32'h23);
    rst = 1'b1;
    #1;
    chk("midrun_reset_diff", 32'(DIFF), 32'd0);
    chk("midrun_reset_bout", 32'(BorrowOUT), 32'd0);
    chk("midrun_reset_done_valid", 32'(done_valid), 32'd0);
    chk("midrun_reset_start_ready", 32'(start_ready), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("post_reset_start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, d, bo);
    chk("post_reset_diff", 32'(d), 32'hF1F0);
    chk("post_reset_bout", 32'(bo), 32'd1);

    // Operand changes after acceptance must not matter
    run_op(16'h5555, 16'h1111, 1'b0, 1'b1, 1'b0, d, bo);
    chk("scramble_diff", 32'(d), 32'h4444);
    chk("scramble_bout", 32'(bo), 32'd0);

    // Random operands against the reference
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rbin;
      ra   = 16'($urandom);
      rb   = (i % 4 == 0) ? ra : 16'($urandom);
      rbin = 1'($urandom);
      exp  = ref_sub(ra, rb, rbin);
      run_op(ra, rb, rbin, 1'b0, 1'b0, d, bo);
      chk($sformatf("rand%0d_diff", i), 32'(d), 32'(exp[15:0]));
      chk($sformatf("rand%0d_bout", i), 32'(bo), 32'(exp[16]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
